// File: rtl/seg7_pkg.sv
// Shared types, glyph constants and FSM encoding for the 7-segment capture decoder.
package seg7_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DATA_W     = NIB_W * NUM_DIGITS;
  localparam int unsigned SMP_W      = SEG_W * NUM_DIGITS;
  localparam int unsigned STAB_W     = 8;

  typedef logic [SEG_W-1:0] seg7_t;
  typedef logic [NIB_W-1:0] nibble_t;

  // Active-high segment patterns, bit6=g .. bit0=a
  localparam seg7_t SEG7_GLYPH_0 = 7'h3F;
  localparam seg7_t SEG7_GLYPH_1 = 7'h06;
  localparam seg7_t SEG7_GLYPH_2 = 7'h5B;
  localparam seg7_t SEG7_GLYPH_3 = 7'h4F;
  localparam seg7_t SEG7_GLYPH_4 = 7'h66;
  localparam seg7_t SEG7_GLYPH_5 = 7'h6D;
  localparam seg7_t SEG7_GLYPH_6 = 7'h7D;
  localparam seg7_t SEG7_GLYPH_7 = 7'h07;
  localparam seg7_t SEG7_GLYPH_8 = 7'h7F;
  localparam seg7_t SEG7_GLYPH_9 = 7'h6F;
  localparam seg7_t SEG7_GLYPH_A = 7'h77;
  localparam seg7_t SEG7_GLYPH_B = 7'h7C;
  localparam seg7_t SEG7_GLYPH_C = 7'h39;
  localparam seg7_t SEG7_GLYPH_D = 7'h5E;
  localparam seg7_t SEG7_GLYPH_E = 7'h79;
  localparam seg7_t SEG7_GLYPH_F = 7'h71;

  typedef enum logic [0:0] {
    ST_WAIT = 1'b0,
    ST_PEND = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] err;
    logic [DATA_W-1:0]     data;
  } cap_word_t;

  // Bring raw display bits to lit-is-one form
  function automatic logic [SMP_W-1:0] seg_normalise(input logic [SMP_W-1:0] raw,
                                                     input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational decode of one active-high 7-segment pattern back to its hex nibble.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  seg7_t   seg,
  output nibble_t nib_c,
  output logic    err_c
);

  // Anything that is not one of the 16 glyphs (blank included) decodes to 0 with err set
  always_comb begin
    nib_c = '0;
    err_c = 1'b0;
    case (seg)
      SEG7_GLYPH_0: nib_c = 4'h0;
      SEG7_GLYPH_1: nib_c = 4'h1;
      SEG7_GLYPH_2: nib_c = 4'h2;
      SEG7_GLYPH_3: nib_c = 4'h3;
      SEG7_GLYPH_4: nib_c = 4'h4;
      SEG7_GLYPH_5: nib_c = 4'h5;
      SEG7_GLYPH_6: nib_c = 4'h6;
      SEG7_GLYPH_7: nib_c = 4'h7;
      SEG7_GLYPH_8: nib_c = 4'h8;
      SEG7_GLYPH_9: nib_c = 4'h9;
      SEG7_GLYPH_A: nib_c = 4'hA;
      SEG7_GLYPH_B: nib_c = 4'hB;
      SEG7_GLYPH_C: nib_c = 4'hC;
      SEG7_GLYPH_D: nib_c = 4'hD;
      SEG7_GLYPH_E: nib_c = 4'hE;
      SEG7_GLYPH_F: nib_c = 4'hF;
      default:      err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture_dec.sv
// Samples six 7-segment buses, waits for a stable display and hands each new decoded word out over valid/ready.
// Optional macro SEG7_CAPTURE_ERRCNT_EN adds a saturating count of accepted words carrying illegal digits.
module seg7_capture_dec
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEG_W-1:0]  HEX5,
  input  logic [SEG_W-1:0]  HEX4,
  input  logic [SEG_W-1:0]  HEX3,
  input  logic [SEG_W-1:0]  HEX2,
  input  logic [SEG_W-1:0]  HEX1,
  input  logic [SEG_W-1:0]  HEX0,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [NUM_DIGITS-1:0] out_err
`ifdef SEG7_CAPTURE_ERRCNT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_THR = STAB_W'(STABLE_CYCLES - 1);

  logic [SMP_W-1:0]      raw_norm_c;
  logic [SMP_W-1:0]      smp_q, smp_d;
  logic [STAB_W-1:0]     stab_cnt_q, stab_cnt_d;
  logic                  stable_c;
  logic [DATA_W-1:0]     dec_data_c;
  logic [NUM_DIGITS-1:0] dec_err_c;
  cap_word_t             dec_word_c;
  cap_state_e            state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  cap_word_t             out_word_q, out_word_d;
  cap_word_t             last_sent_q, last_sent_d;
  logic                  first_done_q, first_done_d;
  logic                  accept_c;

  assign raw_norm_c = seg_normalise({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, SEG_ACTIVE_LOW);

  // Count consecutive identical samples of the whole display, saturating at the window length
  always_comb begin
    smp_d      = raw_norm_c;
    stab_cnt_d = '0;
    if (raw_norm_c == smp_q) begin
      stab_cnt_d = (stab_cnt_q >= STAB_MAX) ? STAB_MAX : stab_cnt_q + STAB_W'(1);
    end
  end

  assign stable_c = (stab_cnt_q >= STAB_THR);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    seg7_hex_dec u_dec (
      .seg   (smp_q[i*SEG_W +: SEG_W]),
      .nib_c (dec_data_c[i*NIB_W +: NIB_W]),
      .err_c (dec_err_c[i])
    );
  end

  assign dec_word_c = '{err: dec_err_c, data: dec_data_c};
  assign accept_c   = out_valid_q && out_ready;

  // Emit a stable word only if it differs from the last accepted one (or nothing was accepted yet)
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    last_sent_d  = last_sent_q;
    first_done_d = first_done_q;
    case (state_q)
      ST_WAIT: begin
        if (stable_c && (!first_done_q || (dec_word_c != last_sent_q))) begin
          out_word_d  = dec_word_c;
          out_valid_d = 1'b1;
          state_d     = ST_PEND;
        end
      end
      ST_PEND: begin
        if (accept_c) begin
          last_sent_d  = out_word_q;
          first_done_d = 1'b1;
          out_valid_d  = 1'b0;
          state_d      = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q        <= '0;
      stab_cnt_q   <= '0;
      state_q      <= ST_WAIT;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      last_sent_q  <= '0;
      first_done_q <= 1'b0;
    end else begin
      smp_q        <= smp_d;
      stab_cnt_q   <= stab_cnt_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      last_sent_q  <= last_sent_d;
      first_done_q <= first_done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_word_q.data;
  assign out_err   = out_word_q.err;

`ifdef SEG7_CAPTURE_ERRCNT_EN
  localparam int unsigned ERRCNT_W = 16;

  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // Accepted words with any illegal digit, held at all-ones once full
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept_c && (out_word_q.err != '0) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_capture_dec.sv
// Self-checking bench for seg7_capture_dec: vector table plus hand-written corner sequences, scoreboard on the output handshake.
module tb_seg7_capture_dec;

  localparam int unsigned STABLE = 4;

  typedef struct {
    logic [41:0] segs;
    logic [23:0] data;
    logic [5:0]  err;
  } vec_t;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [41:0] segs_hi;
  logic [41:0] raw;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [5:0]  out_err;
`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  vec_t        vecs [7];
  exp_t        sb [$];
  exp_t        mon_e;
  logic [41:0] tmp_s;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic        saw_valid;

  assign raw = ~segs_hi;

  always #5 clk = ~clk;

  seg7_capture_dec #(
    .STABLE_CYCLES  (STABLE),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .HEX5      (raw[41:35]),
    .HEX4      (raw[34:28]),
    .HEX3      (raw[27:21]),
    .HEX2      (raw[20:14]),
    .HEX1      (raw[13:7]),
    .HEX0      (raw[6:0]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef SEG7_CAPTURE_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  function automatic logic [41:0] word_segs(input logic [23:0] w);
    logic [41:0] s;
    for (int i = 0; i < 6; i++) s[i*7 +: 7] = glyph[w[i*4 +: 4]];
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid cycle must match the oldest expected word; pop on handshake
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid data=%h err=%h exp=none at %0t", out_data, out_err, $time);
      end else begin
        mon_e = sb[0];
        check("sb_data", 32'(out_data), 32'(mon_e.data));
        check("sb_err", 32'(out_err), 32'(mon_e.err));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    @(posedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_valid(input int max);
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
    end
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic apply_vec(input int idx);
    segs_hi = vecs[idx].segs;
    sb.push_back('{vecs[idx].data, vecs[idx].err});
    wait_drain(STABLE + 6);
    idle(STABLE + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{word_segs(24'hABCDEF), 24'hABCDEF, 6'b000000};
    tmp_s = word_segs(24'h000000);
    tmp_s[27:21] = 7'h00;
    vecs[1] = '{tmp_s, 24'h000000, 6'b001000};
    vecs[2] = '{word_segs(24'h987654), 24'h987654, 6'b000000};
    vecs[3] = '{word_segs(24'h0C0DE0), 24'h0C0DE0, 6'b000000};
    tmp_s = word_segs(24'h0EDCB0);
    tmp_s[41:35] = 7'h40;
    tmp_s[6:0]   = 7'h01;
    vecs[4] = '{tmp_s, 24'h0EDCB0, 6'b100001};
    vecs[5] = '{42'h0, 24'h000000, 6'b111111};
    vecs[6] = '{word_segs(24'h765430), 24'h765430, 6'b000000};

    rst       = 1'b1;
    out_ready = 1'b0;
    segs_hi   = '0;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);

    // First word latency and single emission
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    segs_hi   = word_segs(24'h12345F);
    sb.push_back('{24'h12345F, 6'b000000});
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 32'(lat), 32'(STABLE + 1));
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    idle(STABLE + 6);
    check("no_reemit", 32'(sb.size()), 32'd0);

    for (int i = 0; i < 7; i++) apply_vec(i);

    // Glitching HEX0 never becomes stable
    saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      segs_hi = word_segs((k % 2 == 0) ? 24'h765433 : 24'h765438);
      repeat (2) begin
        @(negedge clk);
        saw_valid = saw_valid | out_valid;
        @(posedge clk);
        #1;
      end
    end
    check("glitch_no_valid", 32'(saw_valid), 32'd0);
    segs_hi = word_segs(24'h765438);
    sb.push_back('{24'h765438, 6'b000000});
    wait_drain(STABLE + 6);
    idle(STABLE + 4);

    // Held word survives a display change while ready is low
    out_ready = 1'b0;
    segs_hi   = word_segs(24'hABCDEF);
    sb.push_back('{24'hABCDEF, 6'b000000});
    wait_valid(STABLE + 6);
    idle(2);
    segs_hi = word_segs(24'h000001);
    sb.push_back('{24'h000001, 6'b000000});
    idle(STABLE + 4);
    check("pend_hold_data", 32'(out_data), 32'hABCDEF);
    check("pend_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_drain(STABLE + 2);
    idle(STABLE + 4);

    // Asynchronous reset in PEND discards the word; it comes back after release
    out_ready = 1'b0;
    segs_hi   = word_segs(24'h0FACE5);
    sb.push_back('{24'h0FACE5, 6'b000000});
    wait_valid(STABLE + 6);
    check("pre_rst_data", 32'(out_data), 32'h0FACE5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    wait_drain(STABLE + 6);
    idle(STABLE + 4);

`ifdef SEG7_CAPTURE_ERRCNT_EN
    rst     = 1'b1;
    segs_hi = vecs[1].segs;
    #2;
    check("errcnt_rst", 32'(err_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_vec(1);
    apply_vec(0);
    apply_vec(4);
    apply_vec(2);
    apply_vec(5);
    check("errcnt_three", 32'(err_cnt), 32'd3);
    force dut.err_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.err_cnt_q;
    apply_vec(1);
    check("errcnt_sat", 32'(err_cnt), 32'h0000FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
